// File: rtl/modulo_counter_if.sv
// Control/status bundle for modulo_counter: step/load/clear controls in, count and status out.
interface modulo_counter_if #(
    parameter int unsigned Size = 5
);
    logic            enable;
    logic            up;
    logic            load;
    logic [Size-1:0] load_value;
    logic            clear;
    logic            overflow_clear;
    logic [Size-1:0] count;
    logic            terminal;
    logic            wrapped;
    logic            overflow;

    modport master (
        output enable, up, load, load_value, clear, overflow_clear,
        input  count, terminal, wrapped, overflow
    );

    modport slave (
        input  enable, up, load, load_value, clear, overflow_clear,
        output count, terminal, wrapped, overflow
    );
endinterface

// File: rtl/modulo_counter.sv
// Up/down modulo counter with load/clear, wrap or saturate, and terminal/wrapped/overflow status.
// Optional step prescaler enabled by defining MODULO_COUNTER_PRESCALE_EN.
module modulo_counter #(
    parameter int unsigned Size     = 5,
    parameter int unsigned Modulo   = 32,
    parameter int unsigned Saturate = 0,
    parameter int unsigned Prescale = 4
) (
    input logic              clock,
    input logic              reset,
    modulo_counter_if.slave  bus
);
    // One extra bit so Modulo == 2**Size compares cleanly.
    localparam int unsigned    CW       = Size + 1;
    localparam logic [CW-1:0]  MOD_EXT  = CW'(Modulo);
    localparam logic [CW-1:0]  LAST_EXT = CW'(Modulo - 1);
    localparam logic [Size-1:0] LAST    = Size'(Modulo - 1);

    if (Modulo < 2 || Modulo > (1 << Size)) begin : g_bad_modulo
        $error("modulo_counter: Modulo out of range");
    end
    if (Prescale < 1) begin : g_bad_prescale
        $error("modulo_counter: Prescale must be >= 1");
    end

    logic [Size-1:0] count_q, count_d;
    logic            wrapped_q, wrapped_d;
    logic            overflow_q, overflow_d;
    logic            at_top, at_bottom, at_bound;
    logic            step, boundary;

    assign at_top    = {1'b0, count_q} == LAST_EXT;
    assign at_bottom = count_q == '0;
    assign at_bound  = bus.up ? at_top : at_bottom;

`ifdef MODULO_COUNTER_PRESCALE_EN
    localparam int unsigned   PW    = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [PW-1:0] PLAST = PW'(Prescale - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          presc_hit;

    assign presc_hit    = presc_q == PLAST;
    assign step         = bus.enable && presc_hit;
    assign bus.terminal = at_bound && presc_hit;

    // Prescaler advances on enable cycles only; clear/load restart it.
    always_comb begin
        presc_d = presc_q;
        if (bus.clear || bus.load) begin
            presc_d = '0;
        end else if (bus.enable) begin
            presc_d = presc_hit ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign step         = bus.enable;
    assign bus.terminal = at_bound;
`endif

    assign boundary = step && at_bound && !bus.clear && !bus.load;

    // Next-state: clear > load > step > hold.
    always_comb begin
        count_d    = count_q;
        wrapped_d  = 1'b0;
        overflow_d = overflow_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = ({1'b0, bus.load_value} < MOD_EXT) ? bus.load_value : LAST;
        end else if (step) begin
            if (bus.up) begin
                if (at_top) count_d = (Saturate != 0) ? LAST : '0;
                else        count_d = count_q + Size'(1);
            end else begin
                if (at_bottom) count_d = (Saturate != 0) ? '0 : LAST;
                else           count_d = count_q - Size'(1);
            end
        end
        if (boundary) begin
            wrapped_d  = 1'b1;
            overflow_d = 1'b1;
        end else if (bus.overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrapped  = wrapped_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_modulo_counter.sv
// Directed bench for modulo_counter: wrap, saturate, full-range modulus and prescaled instances.
module tb_modulo_counter;
`ifdef MODULO_COUNTER_PRESCALE_EN
    localparam bit PRESC_ON = 1'b1;
`else
    localparam bit PRESC_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    modulo_counter_if #(.Size(5)) iw ();
    modulo_counter_if #(.Size(5)) is ();
    modulo_counter_if #(.Size(5)) im ();
    modulo_counter_if #(.Size(5)) ip ();

    modulo_counter #(.Size(5), .Modulo(20), .Saturate(0), .Prescale(1)) dut_w (
        .clock(clock), .reset(reset), .bus(iw));
    modulo_counter #(.Size(5), .Modulo(20), .Saturate(1), .Prescale(1)) dut_s (
        .clock(clock), .reset(reset), .bus(is));
    modulo_counter #(.Size(5), .Modulo(32), .Saturate(0), .Prescale(1)) dut_m (
        .clock(clock), .reset(reset), .bus(im));
    modulo_counter #(.Size(5), .Modulo(20), .Saturate(0), .Prescale(4)) dut_p (
        .clock(clock), .reset(reset), .bus(ip));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iw.enable = 0; iw.up = 0; iw.load = 0; iw.load_value = '0; iw.clear = 0; iw.overflow_clear = 0;
        is.enable = 0; is.up = 0; is.load = 0; is.load_value = '0; is.clear = 0; is.overflow_clear = 0;
        im.enable = 0; im.up = 0; im.load = 0; im.load_value = '0; im.clear = 0; im.overflow_clear = 0;
        ip.enable = 0; ip.up = 0; ip.load = 0; ip.load_value = '0; ip.clear = 0; ip.overflow_clear = 0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("rst_count", 32'(iw.count), 0);
        check("rst_wrapped", 32'(iw.wrapped), 0);
        check("rst_overflow", 32'(iw.overflow), 0);

        // Free-running up count through the 19 -> 0 wrap.
        iw.enable = 1; iw.up = 1;
        #1;
        check("up_term0", 32'(iw.terminal), 0);
        for (int i = 1; i <= 25; i++) begin
            tick();
            check($sformatf("up_count%0d", i), 32'(iw.count), 32'(i % 20));
            check($sformatf("up_wrap%0d", i), 32'(iw.wrapped), 32'(i == 20));
            check($sformatf("up_ovf%0d", i), 32'(iw.overflow), 32'(i >= 20));
            check($sformatf("up_term%0d", i), 32'(iw.terminal), 32'((i % 20) == 19));
        end

        // Load 7 then count down through 0 -> 19.
        iw.load_value = 5'd7; iw.load = 1;
        tick();
        check("ld_count", 32'(iw.count), 7);
        check("ld_wrap", 32'(iw.wrapped), 0);
        iw.load = 0; iw.up = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("dn_count%0d", k), 32'(iw.count), 32'((27 - k) % 20));
            check($sformatf("dn_wrap%0d", k), 32'(iw.wrapped), 32'(k == 8));
            check($sformatf("dn_term%0d", k), 32'(iw.terminal), 32'(k == 7));
        end
        iw.enable = 0; iw.overflow_clear = 1;
        tick();
        check("ovf_clear", 32'(iw.overflow), 0);
        iw.overflow_clear = 0;

        // clear beats load; boundary event beats overflow_clear.
        iw.clear = 1; iw.load = 1; iw.load_value = 5'd5; iw.enable = 1;
        tick();
        check("clr_ld_count", 32'(iw.count), 0);
        iw.clear = 0; iw.load = 0; iw.overflow_clear = 1;
        tick();
        check("set_win_count", 32'(iw.count), 19);
        check("set_win_ovf", 32'(iw.overflow), 1);
        check("set_win_wrap", 32'(iw.wrapped), 1);
        iw.enable = 0;
        tick();
        check("ovfclr2_ovf", 32'(iw.overflow), 0);
        check("ovfclr2_wrap", 32'(iw.wrapped), 0);
        iw.overflow_clear = 0;

        // Asynchronous reset between edges at count 12 with overflow set.
        iw.load_value = 5'd0; iw.load = 1;
        tick();
        iw.load = 0; iw.enable = 1;
        tick();
        check("pre_rst_ovf", 32'(iw.overflow), 1);
        iw.enable = 0; iw.load_value = 5'd12; iw.load = 1;
        tick();
        iw.load = 0;
        check("pre_rst_count", 32'(iw.count), 12);
        #2 reset = 1'b0;
        #1;
        check("arst_count", 32'(iw.count), 0);
        check("arst_wrap", 32'(iw.wrapped), 0);
        check("arst_ovf", 32'(iw.overflow), 0);
        @(negedge clock);
        reset = 1'b1;
        iw.up = 1; iw.enable = 1;
        tick();
        check("resume1", 32'(iw.count), 1);
        tick();
        check("resume2", 32'(iw.count), 2);
        iw.enable = 0;

        // Saturate: clamp on load, hold at both ends with a wrapped pulse per hit.
        is.load_value = 5'd31; is.load = 1; is.up = 1;
        tick();
        check("sat_clamp", 32'(is.count), 19);
        check("sat_term", 32'(is.terminal), 1);
        is.load = 0; is.enable = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("sat_hold%0d", k), 32'(is.count), 19);
            check($sformatf("sat_wrap%0d", k), 32'(is.wrapped), 1);
            check($sformatf("sat_ovf%0d", k), 32'(is.overflow), 1);
        end
        is.up = 0;
        tick();
        check("sat_dn", 32'(is.count), 18);
        check("sat_dn_wrap", 32'(is.wrapped), 0);
        is.enable = 0; is.load_value = 5'd0; is.load = 1;
        tick();
        is.load = 0; is.enable = 1;
        tick();
        check("sat_low", 32'(is.count), 0);
        check("sat_low_wrap", 32'(is.wrapped), 1);
        is.enable = 0;

        // Full-range modulus: 31 is legal and wraps to 0.
        im.load_value = 5'd31; im.load = 1;
        tick();
        check("m32_load", 32'(im.count), 31);
        im.load = 0; im.up = 1; im.enable = 1;
        #1;
        check("m32_term", 32'(im.terminal), 1);
        tick();
        check("m32_wrap_count", 32'(im.count), 0);
        check("m32_wrap", 32'(im.wrapped), 1);
        im.enable = 0;

        // Prescaled instance: one step every 4th enable cycle when the feature is built in.
        ip.up = 1; ip.enable = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("pre_count%0d", k), 32'(ip.count), PRESC_ON ? 32'(k / 4) : 32'(k));
        end
        ip.enable = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
